// File: rtl/r_r16_demux_1_16_out.sv
// Radix-16 SRAM read demux: registers one lane's read command, follows its lane tag
// through the SRAM read latency, and steers the returned word back to that lane.
`ifndef MA_width
`define MA_width 10
`endif
`ifndef D_width
`define D_width 16
`endif

module r_r16_demux_1_16_out #(
  parameter int MA_W   = `MA_width,
  parameter int D_W    = `D_width,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r_enable,
  input  logic [4:0]           sel_in,
  input  logic [16*MA_W-1:0]   A_in,
  input  logic [D_W-1:0]       Q_in,
  output logic                 CEN_out,
  output logic [MA_W-1:0]      A_out,
  output logic                 WEN_out,
  output logic [16*D_W-1:0]    D_out,
  output logic [15:0]          valid_out,
  output logic [2:0]           rd_pending,
  output logic                 busy
);

  logic                     req;
  logic [3:0]               laneSel;
  logic [MA_W-1:0]          aSel;

  logic                     cen_q;
  logic [MA_W-1:0]          a_q;
  logic [3:0]               cmdLane_q;
  logic [RD_LAT-1:0]        tagV_q;
  logic [RD_LAT-1:0][3:0]   tagLane_q;
  logic [16*D_W-1:0]        dOut_q, dOut_d;
  logic [15:0]              valid_q, valid_d;
  logic [2:0]               pend_q, pend_d;

  logic                     capture;
  logic [3:0]               capLane;

  // Lane selects 16..31 carry a set MSB and are simply not requests.
  assign req     = r_enable & ~sel_in[4];
  assign laneSel = sel_in[3:0];
  assign aSel    = A_in[int'(laneSel)*MA_W +: MA_W];

  assign capture = tagV_q[RD_LAT-1];
  assign capLane = tagLane_q[RD_LAT-1];

  always_comb begin
    valid_d = '0;
    dOut_d  = dOut_q;
    pend_d  = pend_q;
    if (capture) begin
      valid_d[capLane]                   = 1'b1;
      dOut_d[int'(capLane)*D_W +: D_W]   = Q_in;
    end
    case ({req, capture})
      2'b10:   pend_d = pend_q + 3'd1;
      2'b01:   pend_d = pend_q - 3'd1;
      default: pend_d = pend_q;
    endcase
  end

  // The command register acts as tag stage zero, so RD_LAT further stages land
  // the tag at the tail exactly in the cycle Q_in is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cen_q     <= 1'b1;
      a_q       <= '0;
      cmdLane_q <= '0;
      tagV_q    <= '0;
      tagLane_q <= '0;
      dOut_q    <= '0;
      valid_q   <= '0;
      pend_q    <= '0;
    end else begin
      cen_q <= ~req;
      if (req) begin
        a_q       <= aSel;
        cmdLane_q <= laneSel;
      end
      tagV_q[0]    <= ~cen_q;
      tagLane_q[0] <= cmdLane_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tagV_q[i]    <= tagV_q[i-1];
        tagLane_q[i] <= tagLane_q[i-1];
      end
      dOut_q  <= dOut_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign CEN_out    = cen_q;
  assign A_out      = a_q;
  assign WEN_out    = 1'b1;
  assign D_out      = dOut_q;
  assign valid_out  = valid_q;
  assign rd_pending = pend_q;
  assign busy       = (pend_q != 3'd0) | ~cen_q;

endmodule

// File: tb/tb_r_r16_demux_1_16_out.sv
// Bench for r_r16_demux_1_16_out: two instances (RD_LAT 1 and 3) share stimulus, each
// with its own SRAM model, checked against a queue of expected lane returns.
module tb_r_r16_demux_1_16_out;

  localparam int MA_W = 10;
  localparam int D_W  = 16;

  typedef struct {
    logic [3:0]     lane;
    logic [D_W-1:0] data;
    int             due;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                r_enable = 1'b0;
  logic [4:0]          sel_in = '0;
  logic [16*MA_W-1:0]  aIn = '0;
  logic [D_W-1:0]      qIn [2];
  logic                cenOut [2];
  logic                wenOut [2];
  logic [MA_W-1:0]     aOut [2];
  logic [16*D_W-1:0]   dOut [2];
  logic [15:0]         validOut [2];
  logic [2:0]          pend [2];
  logic                busyOut [2];

  int                  vectors = 0;
  int                  miscompares = 0;
  int                  cyc = 0;
  bit                  checkEn = 1'b0;

  logic [D_W-1:0]      mem [0:(1<<MA_W)-1];
  exp_t                sbQ [2][$];
  logic [16*D_W-1:0]   expD [2];
  logic                histCen [2][0:4];
  logic [MA_W-1:0]     histA [2][0:4];

  r_r16_demux_1_16_out #(.MA_W(MA_W), .D_W(D_W), .RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .sel_in(sel_in), .A_in(aIn),
    .Q_in(qIn[0]), .CEN_out(cenOut[0]), .A_out(aOut[0]), .WEN_out(wenOut[0]),
    .D_out(dOut[0]), .valid_out(validOut[0]), .rd_pending(pend[0]), .busy(busyOut[0]));

  r_r16_demux_1_16_out #(.MA_W(MA_W), .D_W(D_W), .RD_LAT(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .sel_in(sel_in), .A_in(aIn),
    .Q_in(qIn[1]), .CEN_out(cenOut[1]), .A_out(aOut[1]), .WEN_out(wenOut[1]),
    .D_out(dOut[1]), .valid_out(validOut[1]), .rd_pending(pend[1]), .busy(busyOut[1]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // SRAM models and the scoreboard consumer both live on the falling edge.
  always @(negedge clk) begin
    logic [15:0] expV;
    exp_t        e;
    for (int d = 0; d < 2; d++) begin
      for (int k = 4; k > 0; k--) begin
        histCen[d][k] = histCen[d][k-1];
        histA[d][k]   = histA[d][k-1];
      end
      histCen[d][0] = cenOut[d];
      histA[d][0]   = aOut[d];
      qIn[d] = (histCen[d][latOf(d)] === 1'b0) ? mem[histA[d][latOf(d)]] : 16'hDEAD;

      if (!rst_n) begin
        sbQ[d].delete();
        expD[d] = '0;
      end
      if (checkEn) begin
        expV = '0;
        if (sbQ[d].size() > 0 && sbQ[d][0].due == cyc) begin
          e = sbQ[d].pop_front();
          expV[e.lane] = 1'b1;
          expD[d][int'(e.lane)*D_W +: D_W] = e.data;
        end
        vectors++;
        if (validOut[d] !== expV) begin
          miscompares++;
          $display("[TB] FAIL sb_valid dut%0d cyc %0d: got %h expected %h", d, cyc, validOut[d], expV);
        end
        vectors++;
        if (dOut[d] !== expD[d]) begin
          miscompares++;
          $display("[TB] FAIL sb_dout dut%0d cyc %0d: got %h expected %h", d, cyc, dOut[d], expD[d]);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic setLane(input int lane, input logic [MA_W-1:0] addr);
    aIn[lane*MA_W +: MA_W] = addr;
  endtask

  task automatic drive(input logic en, input logic [4:0] sel);
    exp_t e;
    r_enable = en;
    sel_in   = sel;
    if (rst_n && en && !sel[4]) begin
      for (int d = 0; d < 2; d++) begin
        e.lane = sel[3:0];
        e.data = mem[aIn[int'(sel[3:0])*MA_W +: MA_W]];
        e.due  = cyc + 2 + latOf(d);
        sbQ[d].push_back(e);
      end
    end
  endtask

  task automatic drain();
    drive(1'b0, 5'd0);
    for (int i = 0; i < 20 && (sbQ[0].size() != 0 || sbQ[1].size() != 0); i++) step();
    vectors++;
    if (sbQ[0].size() != 0 || sbQ[1].size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d/%0d outstanding expected 0", sbQ[0].size(), sbQ[1].size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    setLane(3, 10'h055);
    drive(1'b1, 5'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      checkEn = 1'b1;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (cenOut[d] !== 1'b1 || wenOut[d] !== 1'b1 || aOut[d] !== '0 ||
            validOut[d] !== '0 || pend[d] !== 3'd0 || busyOut[d] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL reset_state dut%0d: got cen=%b wen=%b a=%h v=%h p=%0d b=%b expected 1 1 0 0 0 0",
                   d, cenOut[d], wenOut[d], aOut[d], validOut[d], pend[d], busyOut[d]);
        end
      end
    end
    rst_n = 1'b1;
    drive(1'b1, 5'd3);
    vectors++;
    if (cenOut[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release_cen: got %b expected 1", cenOut[0]);
    end
    step();
    drive(1'b0, 5'd0);
    vectors++;
    if (cenOut[0] !== 1'b0 || aOut[0] !== 10'h055) begin
      miscompares++;
      $display("[TB] FAIL first_cmd: got cen=%b a=%h expected cen=0 a=055", cenOut[0], aOut[0]);
    end
    drain();
  endtask

  task automatic test_single_read();
    setLane(5, 10'h02A);
    drive(1'b1, 5'd5);
    step();
    drive(1'b0, 5'd0);
    vectors++;
    if (cenOut[0] !== 1'b0 || aOut[0] !== 10'h02A || wenOut[0] !== 1'b1 ||
        pend[0] !== 3'd1 || busyOut[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_cmd: got cen=%b a=%h wen=%b p=%0d b=%b expected 0 02a 1 1 1",
               cenOut[0], aOut[0], wenOut[0], pend[0], busyOut[0]);
    end
    step();
    vectors++;
    if (cenOut[0] !== 1'b1 || pend[0] !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL single_wait: got cen=%b p=%0d expected cen=1 p=1", cenOut[0], pend[0]);
    end
    step();
    vectors++;
    if (validOut[0] !== 16'h0020 || dOut[0][5*D_W +: D_W] !== 16'hBEEF ||
        pend[0] !== 3'd0 || busyOut[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_return: got v=%h d5=%h p=%0d b=%b expected 0020 beef 0 0",
               validOut[0], dOut[0][5*D_W +: D_W], pend[0], busyOut[0]);
    end
    drain();
  endtask

  task automatic test_streaming();
    int          peak0;
    int          peak1;
    int          ts;
    logic [15:0] expV;
    peak0 = 0;
    peak1 = 0;
    ts    = 0;
    for (int k = 0; k < 16; k++) setLane(k, MA_W'(10'h100 + k * 7));
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive(1'b1, 5'(k));
      else drive(1'b0, 5'd0);
      step();
      ts++;
      if (int'(pend[0]) > peak0) peak0 = int'(pend[0]);
      if (int'(pend[1]) > peak1) peak1 = int'(pend[1]);
      expV = '0;
      if (ts >= 3 && ts <= 18) expV[ts-3] = 1'b1;
      vectors++;
      if (validOut[0] !== expV) begin
        miscompares++;
        $display("[TB] FAIL stream_walk cycle %0d: got %h expected %h", ts, validOut[0], expV);
      end
    end
    vectors++;
    if (peak0 != 2 || peak1 != 4) begin
      miscompares++;
      $display("[TB] FAIL stream_peak: got %0d/%0d expected 2/4", peak0, peak1);
    end
    vectors++;
    if (pend[0] !== 3'd0 || busyOut[0] !== 1'b0 || pend[1] !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL stream_end: got p0=%0d b0=%b p1=%0d expected 0 0 2", pend[0], busyOut[0], pend[1]);
    end
    drain();
  endtask

  task automatic test_invalid_select();
    drive(1'b1, 5'd16);
    step();
    drive(1'b1, 5'd31);
    vectors++;
    if (cenOut[0] !== 1'b1 || pend[0] !== 3'd0 || cenOut[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL invalid16: got cen=%b p=%0d expected cen=1 p=0", cenOut[0], pend[0]);
    end
    step();
    drive(1'b0, 5'd0);
    vectors++;
    if (cenOut[0] !== 1'b1 || pend[0] !== 3'd0 || busyOut[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL invalid31: got cen=%b p=%0d b=%b expected 1 0 0", cenOut[0], pend[0], busyOut[0]);
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset_midflight();
    setLane(7, 10'h077);
    drive(1'b1, 5'd7);
    step();
    drive(1'b0, 5'd0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (validOut[0] !== '0 || dOut[0][7*D_W +: D_W] !== '0 || pend[0] !== 3'd0 || pend[1] !== 3'd0) begin
        miscompares++;
        $display("[TB] FAIL midflight_reset: got v=%h d7=%h p0=%0d p1=%0d expected 0 0 0 0",
                 validOut[0], dOut[0][7*D_W +: D_W], pend[0], pend[1]);
      end
      step();
    end
  endtask

  task automatic test_same_lane();
    setLane(9, 10'h030);
    drive(1'b1, 5'd9);
    step();
    setLane(9, 10'h031);
    drive(1'b1, 5'd9);
    step();
    drive(1'b0, 5'd0);
    for (int i = 2; i < 5; i++) step();
    vectors++;
    if (validOut[1] !== 16'h0200 || dOut[1][9*D_W +: D_W] !== 16'h0011) begin
      miscompares++;
      $display("[TB] FAIL same_lane_first: got v=%h d9=%h expected 0200 0011", validOut[1], dOut[1][9*D_W +: D_W]);
    end
    step();
    vectors++;
    if (validOut[1] !== 16'h0200 || dOut[1][9*D_W +: D_W] !== 16'h0022) begin
      miscompares++;
      $display("[TB] FAIL same_lane_second: got v=%h d9=%h expected 0200 0022", validOut[1], dOut[1][9*D_W +: D_W]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 16; k++) setLane(k, MA_W'($urandom_range(0, (1 << MA_W) - 1)));
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 19)));
      step();
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < (1 << MA_W); i++) mem[i] = 16'(i * 37 + 16'h1000);
    mem[10'h02A] = 16'hBEEF;
    mem[10'h030] = 16'h0011;
    mem[10'h031] = 16'h0022;
    test_reset();
    test_single_read();
    test_streaming();
    test_invalid_select();
    test_reset_midflight();
    test_same_lane();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
